// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU codes, opcode/funct values, control FSM states.
// MC_MULDIV_EN enables the mul/div R-type functs in r_decode.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_MUL = 4'd2,
                         ALU_DIV = 4'd3,  ALU_XOR = 4'd4,  ALU_AND = 4'd5,
                         ALU_OR  = 4'd6,  ALU_NOT = 4'd7,  ALU_NOR = 4'd8,
                         ALU_SLT = 4'd9,  ALU_SLL = 4'd10, ALU_SRL = 4'd11,
                         ALU_SRA = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_SLTI = 6'h0A,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_BEQ  = 6'h04,
                         OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_MUL = 6'h18,
                         FN_DIV = 6'h1A, FN_XOR = 6'h26, FN_AND = 6'h24,
                         FN_OR  = 6'h25, FN_NOT = 6'h28, FN_NOR = 6'h27,
                         FN_SLT = 6'h2A, FN_SLL = 6'h04, FN_SRL = 6'h06,
                         FN_SRA = 6'h07;

  localparam logic [2:0] SRCB_B = 3'd0, SRCB_4 = 3'd1, SRCB_SIMM = 3'd2,
                         SRCB_ZIMM = 3'd3, SRCB_BOFF = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BEQ_CMP, S_BEQ_TGT, S_BEQ_UPD, S_JUMP,
    S_ILLEGAL
  } state_t;

  // {valid, alu code} for an R-type funct
  function automatic logic [4:0] r_decode(input logic [5:0] fn);
    case (fn)
      FN_ADD:  return {1'b1, ALU_ADD};
      FN_SUB:  return {1'b1, ALU_SUB};
`ifdef MC_MULDIV_EN
      FN_MUL:  return {1'b1, ALU_MUL};
      FN_DIV:  return {1'b1, ALU_DIV};
`endif
      FN_XOR:  return {1'b1, ALU_XOR};
      FN_AND:  return {1'b1, ALU_AND};
      FN_OR:   return {1'b1, ALU_OR};
      FN_NOT:  return {1'b1, ALU_NOT};
      FN_NOR:  return {1'b1, ALU_NOR};
      FN_SLT:  return {1'b1, ALU_SLT};
      FN_SLL:  return {1'b1, ALU_SLL};
      FN_SRL:  return {1'b1, ALU_SRL};
      FN_SRA:  return {1'b1, ALU_SRA};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

  function automatic logic [3:0] i_alu(input logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_control.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute/memory/writeback.
// Build option MC_MULDIV_EN (see cpu_pkg) adds mul/div R-type decode.
module mc_control
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] ALUControl,
  output logic       alu_srca_sel,
  output logic [2:0] alu_srcb_sel,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_we,
  output logic       pc_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t     state, state_nx;
  logic       br_take;
  logic [4:0] r_dec;

  assign r_dec   = r_decode(funct);
  assign state_o = state;

  // zero is only valid for the beq compare during BEQ_TGT; latch it there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      br_take <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_BEQ_TGT) br_take <= zero;
    end
  end

  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_IDLE:    state_nx = S_FETCH;
      S_FETCH:   state_nx = S_DECODE;
      S_DECODE:
        case (opcode)
          OP_RTYPE:                                   state_nx = r_dec[4] ? S_EXEC_R : S_ILLEGAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_nx = S_EXEC_I;
          OP_LW, OP_SW:                               state_nx = S_MEM_ADR;
          OP_BEQ:                                     state_nx = S_BEQ_CMP;
          OP_J:                                       state_nx = S_JUMP;
          default:                                    state_nx = S_ILLEGAL;
        endcase
      S_EXEC_R,
      S_EXEC_I:  state_nx = S_ALU_WB;
      S_MEM_ADR: state_nx = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_nx = S_MEM_WB;
      S_BEQ_CMP: state_nx = S_BEQ_TGT;
      S_BEQ_TGT: state_nx = S_BEQ_UPD;
      default:   state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    ALUControl   = ALU_ADD;
    alu_srca_sel = 1'b0;
    alu_srcb_sel = SRCB_B;
    ir_we        = 1'b0;
    iord         = 1'b0;
    mem_we       = 1'b0;
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    case (state)
      S_FETCH: begin
        ir_we        = 1'b1;
        alu_srcb_sel = SRCB_4;
      end
      S_DECODE:  pc_we = 1'b1;
      S_EXEC_R: begin
        alu_srca_sel = 1'b1;
        ALUControl   = r_dec[3:0];
      end
      S_EXEC_I: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = (opcode == OP_ADDI || opcode == OP_SLTI) ? SRCB_SIMM : SRCB_ZIMM;
        ALUControl   = i_alu(opcode);
      end
      S_ALU_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        instr_done = 1'b1;
      end
      S_MEM_ADR: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = SRCB_SIMM;
      end
      S_MEM_RD:  iord = 1'b1;
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        iord       = 1'b1;
        mem_we     = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ_CMP: begin
        alu_srca_sel = 1'b1;
        ALUControl   = ALU_SUB;
      end
      S_BEQ_TGT: alu_srcb_sel = SRCB_BOFF;
      S_BEQ_UPD: begin
        pc_we      = br_take;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_we      = 1'b1;
        pc_src     = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-instruction expected output trace is
// queued at issue time and checked cycle by cycle by an independent monitor.
module tb_mc_control;
  import cpu_pkg::*;

  logic       clk = 1'b0, rst_n, zero;
  logic [5:0] opcode, funct;
  logic [3:0] ALUControl, state_o;
  logic [2:0] alu_srcb_sel;
  logic       alu_srca_sel, ir_we, iord, mem_we, reg_we, reg_dst, mem_to_reg;
  logic       pc_we, pc_src, instr_done, illegal;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .ALUControl(ALUControl), .alu_srca_sel(alu_srca_sel), .alu_srcb_sel(alu_srcb_sel),
    .ir_we(ir_we), .iord(iord), .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .pc_we(pc_we), .pc_src(pc_src), .instr_done(instr_done),
    .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic       srca;
    logic [2:0] srcb;
    logic       ir_we, iord, mem_we, reg_we, reg_dst, mem_to_reg, pc_we, pc_src, done, ill;
    logic [3:0] st;
  } vec_t;

  vec_t sb[$];
  int   n_chk = 0, n_pass = 0;

  function automatic vec_t v(input logic [3:0] st);
    vec_t r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic vec_t act();
    vec_t r;
    r = '{ALUControl, alu_srca_sel, alu_srcb_sel, ir_we, iord, mem_we, reg_we, reg_dst,
          mem_to_reg, pc_we, pc_src, instr_done, illegal, state_o};
    return r;
  endfunction

  task automatic check(input string nm, input vec_t a, input vec_t e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  // reference ALU code tables; -1 means not decodable
  function automatic int ref_r(input logic [5:0] fn);
    case (fn)
      6'h20: return 0;   6'h22: return 1;   6'h26: return 4;   6'h24: return 5;
      6'h25: return 6;   6'h28: return 7;   6'h27: return 8;   6'h2A: return 9;
      6'h04: return 10;  6'h06: return 11;  6'h07: return 12;
`ifdef MC_MULDIV_EN
      6'h18: return 2;   6'h1A: return 3;
`endif
      default: return -1;
    endcase
  endfunction

  function automatic int ref_i(input logic [5:0] op);
    case (op)
      6'h08: return 0;  6'h0A: return 9;  6'h0C: return 5;
      6'h0D: return 6;  6'h0E: return 4;
      default: return -1;
    endcase
  endfunction

  // expected per-cycle trace of one instruction starting at FETCH
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] zv);
    vec_t t;
    int   rc = ref_r(fn), ic = ref_i(op);
    t = v(S_FETCH);  t.ir_we = 1; t.srcb = 3'd1; sb.push_back(t);
    t = v(S_DECODE); t.pc_we = 1; sb.push_back(t);
    if (op == 6'h00 && rc >= 0) begin
      t = v(S_EXEC_R); t.srca = 1; t.alu = 4'(rc); sb.push_back(t);
      t = v(S_ALU_WB); t.reg_we = 1; t.reg_dst = 1; t.done = 1; sb.push_back(t);
    end else if (ic >= 0) begin
      t = v(S_EXEC_I); t.srca = 1; t.alu = 4'(ic);
      t.srcb = (op == 6'h08 || op == 6'h0A) ? 3'd2 : 3'd3; sb.push_back(t);
      t = v(S_ALU_WB); t.reg_we = 1; t.done = 1; sb.push_back(t);
    end else if (op == 6'h23 || op == 6'h2B) begin
      t = v(S_MEM_ADR); t.srca = 1; t.srcb = 3'd2; sb.push_back(t);
      if (op == 6'h23) begin
        t = v(S_MEM_RD); t.iord = 1; sb.push_back(t);
        t = v(S_MEM_WB); t.reg_we = 1; t.mem_to_reg = 1; t.done = 1; sb.push_back(t);
      end else begin
        t = v(S_MEM_WR); t.iord = 1; t.mem_we = 1; t.done = 1; sb.push_back(t);
      end
    end else if (op == 6'h04) begin
      t = v(S_BEQ_CMP); t.srca = 1; t.alu = 4'd1; sb.push_back(t);
      t = v(S_BEQ_TGT); t.srcb = 3'd4; sb.push_back(t);
      t = v(S_BEQ_UPD); t.pc_we = zv[3]; t.done = 1; sb.push_back(t);
    end else if (op == 6'h02) begin
      t = v(S_JUMP); t.pc_we = 1; t.pc_src = 1; t.done = 1; sb.push_back(t);
    end else begin
      t = v(S_ILLEGAL); t.ill = 1; sb.push_back(t);
    end
  endtask

  // drives one instruction; returns in its last cycle, 1ns after the edge
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] zv);
    int n0, n;
    @(posedge clk); #1;
    opcode = op; funct = fn; zero = zv[0];
    n0 = sb.size();
    push_instr(op, fn, zv);
    n = sb.size() - n0;
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
      zero = zv[k];
    end
  endtask

  always @(negedge clk) begin
    vec_t e;
    if (rst_n === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("cycle_state%0d", e.st), act(), e);
    end
  end

  logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                           6'h23, 6'h2B, 6'h04, 6'h04, 6'h02, 6'h3F};
  logic [5:0] fns [14] = '{6'h20, 6'h22, 6'h18, 6'h1A, 6'h26, 6'h24, 6'h25, 6'h28,
                           6'h27, 6'h2A, 6'h04, 6'h06, 6'h07, 6'h3F};

  initial begin
    logic [5:0] op, fn;
    rst_n = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", act(), v(S_IDLE));
    sb.push_back(v(S_IDLE));
    rst_n = 1'b1;

    run(6'h00, 6'h20, 5'b00000);   // add
    run(6'h04, 6'h00, 5'b01000);   // beq, zero in BEQ_TGT: taken
    run(6'h04, 6'h00, 5'b00100);   // beq, zero only in BEQ_CMP: not taken
    run(6'h04, 6'h00, 5'b10111);   // beq not taken, zero high elsewhere
    run(6'h23, 6'h00, 5'b00000);   // lw
    run(6'h2B, 6'h00, 5'b00000);   // sw
    run(6'h0D, 6'h00, 5'b00000);   // ori
    run(6'h02, 6'h00, 5'b11111);   // j
    run(6'h3F, 6'h00, 5'b00000);   // undecodable opcode
    run(6'h00, 6'h1A, 5'b00000);   // div
    run(6'h00, 6'h18, 5'b00000);   // mul

    // reset asserted in the middle of a store's MEM_WR cycle
    run(6'h2B, 6'h00, 5'b00000);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 check("reset_mid_memwr", act(), v(S_IDLE));
    @(posedge clk); #1;
    sb.push_back(v(S_IDLE));
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 13)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 13)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      run(op, fn, 5'($urandom));
    end

    @(negedge clk); #1;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected cycles left, required 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit driving the main ALU and datapath of the multi-cycle CPU. Decodes the instruction register and sequences fetch/decode/execute/memory/writeback, emitting the 4-bit ALU opcode and datapath strobes. It accounts for the ALU's registered outputs: `ALUout` and `zero` appear one cycle after the controlling state.

## Interface
- none (no parameters)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `opcode`  in  6  instr[31:26] from IR
- `funct`  in  6  instr[5:0] from IR
- `zero`  in  1  ALU zero flag (registered by ALU)
- `ALUControl`  out  4  ALU opcode (add 0000 … sra 1100)
- `alu_srca_sel`  out  1  0 = PC, 1 = A register
- `alu_srcb_sel`  out  3  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = zero-ext imm, 4 = sign-ext imm<<2
- `ir_we`  out  1  load IR from memory
- `iord`  out  1  memory address: 0 = PC, 1 = ALUout
- `mem_we`  out  1  memory write
- `reg_we`  out  1  register-file write
- `reg_dst`  out  1  0 = rt, 1 = rd
- `mem_to_reg`  out  1  0 = ALUout, 1 = MDR
- `pc_we`  out  1  PC write
- `pc_src`  out  1  0 = ALUout, 1 = jump target {PC[31:28], instr[25:0], 2'b00}
- `instr_done`  out  1  one-cycle pulse in final state of each instruction
- `illegal`  out  1  one-cycle pulse on undecodable opcode/funct
- `state_o`  out  4  current state, for debug

## Operation
- Moore FSM; all outputs are pure decodes of the state register plus `opcode`/`funct`.
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BEQ_CMP, BEQ_TGT, BEQ_UPD, JUMP, ILLEGAL.
- IDLE: all strobes 0; next FETCH.
- FETCH: ir_we, iord=0, ALU ADD PC + 4.
- DECODE: pc_we, pc_src=0 (PC ← PC+4 from ALUout). Branch on opcode: 0x00 → EXEC_R; 0x08/0x0A/0x0C/0x0D/0x0E → EXEC_I; 0x23/0x2B → MEM_ADR; 0x04 → BEQ_CMP; 0x02 → JUMP; else ILLEGAL.
- EXEC_R: srca=A, srcb=B, code by funct: 0x20 add, 0x22 sub, 0x18 mul, 0x1A div, 0x26 xor, 0x24 and, 0x25 or, 0x28 not, 0x27 nor, 0x2A slt, 0x04 sll, 0x06 srl, 0x07 sra. Unknown funct → ILLEGAL (no write); else → ALU_WB with reg_dst=1.
- EXEC_I: srca=A. addi/slti use sign-ext imm; andi/ori/xori use zero-ext imm. → ALU_WB with reg_dst=0.
- ALU_WB: reg_we, mem_to_reg=0; instr_done → FETCH.
- MEM_ADR: ADD A + sign-ext imm. → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: iord=1 → MEM_WB. MEM_WB: reg_we, reg_dst=0, mem_to_reg=1, instr_done.
- MEM_WR: iord=1, mem_we, instr_done.
- BEQ_CMP: SUB A − B.
- BEQ_TGT: ADD PC + imm<<2; internal `br_take` ← `zero`. `zero` is sampled only here, because the ALU overwrites it at this cycle's end.
- BEQ_UPD: pc_we = br_take, pc_src=0, instr_done.
- JUMP: pc_we, pc_src=1, instr_done.
- ILLEGAL: illegal=1, no writes → FETCH.
- Non-ALU states drive ALUControl=ADD, selectors 0.

## Timing
- Reset (async, any state, mid-instruction included): state=IDLE, br_take=0, all strobes 0, ALUControl=0000, selectors 0, state_o=IDLE code. No partial writes complete.
- Cycle counts from FETCH, inclusive:
  - R-type/I-type ALU: 4
  - sw: 4
  - lw: 5
  - beq: 5
  - j: 3
  - illegal: 3
- Exactly one of reg_we/mem_we/pc_we-in-final-state per instruction; ir_we only in FETCH.
- beq not-taken: no pc_we in BEQ_UPD; PC keeps PC+4.

## Configuration
- `MC_MULDIV_EN` defined: funct 0x18/0x1A decode to mul (0010)/div (0011).
- `MC_MULDIV_EN` undefined: those functs take the ILLEGAL path; codes 0010/0011 never emitted.

## Structure
- Shared package `cpu_pkg`:
  - ALU opcode constants (ALU_ADD … ALU_SRA)
  - opcode/funct constants
  - state enum
  - srcb select constants
- Single module; next-state logic and output decode as two always blocks. No sub-module.

## Test plan
- add (funct 0x20) from reset release → IDLE, FETCH, DECODE, EXEC_R (ALUControl=0000, srcb=0), ALU_WB (reg_we=1, reg_dst=1, instr_done=1).
- beq with zero=1 in BEQ_TGT → BEQ_UPD pc_we=1. Repeat with zero=1 in BEQ_CMP and zero=0 in BEQ_TGT → pc_we=0.
- lw (0x23) → MEM_ADR srcb=2, MEM_RD iord=1, MEM_WB reg_we=1, mem_to_reg=1. sw (0x2B) → MEM_WR mem_we=1, reg_we=0.
- ori (0x0D) → EXEC_I ALUControl=0110, srcb=3. j (0x02) → JUMP pc_we=1, pc_src=1 on third cycle.
- opcode 0x3F → ILLEGAL illegal=1 one cycle, no writes, then FETCH. With `MC_MULDIV_EN` undefined, funct 0x1A gives the same result.
- rst_n low during MEM_WR → mem_we drops immediately; after release, IDLE then FETCH.
